// File: rtl/game_check_if.sv
// ----------------------------------------------------------------------------
// game_check_if
//
// Purpose:
//   Register-file read bus between the answer checker and the register file
//   that the display/store stage fills. Reads are purely combinational: the
//   register file presents q for whatever address rn currently holds.
//
// Signals:
//   rn  [3:0]  read address, driven by the checker
//   q   [9:0]  read data for address rn, driven by the register file
//
// Modports:
//   master  checker side   (drives rn, receives q)
//   slave   regfile side   (receives rn, drives q)
// ----------------------------------------------------------------------------
interface game_check_if;

  logic [3:0] rn;
  logic [9:0] q;

  // The checker owns the address and only ever reads.
  modport master (
    output rn,
    input  q
  );

  // The register file answers whatever address is presented.
  modport slave (
    input  rn,
    output q
  );

endinterface

// File: rtl/game_check.sv
// ----------------------------------------------------------------------------
// game_check
//
// Purpose:
//   Answer-checking stage of the memory game. After the display stage has
//   written DISPLAY_CYCLE values into the register file and raised
//   check_start, this block reads the entries back one at a time, waits for
//   the player to set the switches and press the confirm key, compares the
//   switch value with the stored value and keeps a running score. At the end
//   of the round it reports done, pass and the final score.
//
// Optional feature (macro GAME_CHECK_TIMEOUT_EN):
//   When defined, each entry has an answer window of TIMEOUT_CYCLES clocks.
//   If no press arrives in that window the entry is forced through the
//   compare as wrong and timeout_flag pulses for one cycle. When undefined
//   there is no counter, no timeout_flag port and WAIT lasts indefinitely.
//
// Parameters:
//   DISPLAY_CYCLE   entries per round, 1..15, must match the display stage
//   TIMEOUT_CYCLES  per-entry answer window (only with GAME_CHECK_TIMEOUT_EN)
//
// Ports:
//   clk           system clock, all logic on the rising edge
//   resetn        asynchronous active-low reset
//   check_start   level, starts a round from IDLE or DONE
//   confirm_key   raw active-low push button, asynchronous to clk
//   sw[9:0]       player answer switches
//   rf            register-file read bus (master: rn out, q in)
//   busy          high while a round is in progress
//   done          high from end of round until the next round starts
//   pass          valid while done, high when every entry matched
//   score[3:0]    number of correct entries so far
//   led[9:0]      sw while waiting for an answer, 3FF on pass, 000 on fail
//   timeout_flag  one-cycle pulse per timed-out entry (feature only)
// ----------------------------------------------------------------------------
module game_check #(
  parameter int DISPLAY_CYCLE = 10
`ifdef GAME_CHECK_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 50000000
`endif
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        check_start,
  input  logic        confirm_key,
  input  logic [9:0]  sw,
  game_check_if.master rf,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [3:0]  score,
  output logic [9:0]  led
`ifdef GAME_CHECK_TIMEOUT_EN
  , output logic      timeout_flag
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    WAIT,
    COMPARE,
    DONE
  } state_t;

  localparam logic [3:0] LAST_INDEX = 4'(DISPLAY_CYCLE - 1);
  localparam logic [3:0] ROUND_SIZE = 4'(DISPLAY_CYCLE);

  state_t     r_state;
  state_t     w_stateNext;

  logic [3:0] r_index;
  logic [3:0] w_indexNext;
  logic [3:0] r_rn;
  logic [3:0] w_rnNext;
  logic [9:0] r_expected;
  logic [9:0] w_expectedNext;
  logic [9:0] r_answer;
  logic [9:0] w_answerNext;
  logic [3:0] r_score;
  logic [3:0] w_scoreNext;
  logic       r_done;
  logic       w_doneNext;
  logic       r_pass;
  logic       w_passNext;

  logic       r_keySync1;
  logic       r_keySync2;
  logic       r_keyPrev;
  logic       w_press;

  logic       w_timeout;
  logic       w_forceMiss;

  // The key is asynchronous, so it goes through two flops before anything
  // looks at it. A third flop holds the previous synchronized level so a
  // falling edge (key pressed, active-low) becomes a single-cycle pulse.
  // All three clear to 1 so that reset looks like a released key and can
  // never fabricate a press.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_keySync1 <= 1'b1;
      r_keySync2 <= 1'b1;
      r_keyPrev  <= 1'b1;
    end else begin
      r_keySync1 <= confirm_key;
      r_keySync2 <= r_keySync1;
      r_keyPrev  <= r_keySync2;
    end
  end

  assign w_press = r_keyPrev & ~r_keySync2;

`ifdef GAME_CHECK_TIMEOUT_EN
  localparam logic [25:0] TIMEOUT_LAST = 26'(TIMEOUT_CYCLES - 1);

  logic [25:0] r_toCount;
  logic        r_miss;
  logic        r_timeoutFlag;

  // A press arriving in the very cycle the window closes wins over the
  // timeout, so the timeout is suppressed whenever w_press is high.
  assign w_timeout = (r_state == WAIT) && (r_toCount == TIMEOUT_LAST) && !w_press;

  // Answer-window counter: cleared in LOAD so it starts from zero on the
  // first WAIT cycle, then counts every WAIT cycle. r_miss records whether
  // WAIT was left through the timeout so COMPARE can refuse the point even
  // if the stale answer register happens to match. timeout_flag is simply
  // the timeout condition delayed by one cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_toCount     <= '0;
      r_miss        <= 1'b0;
      r_timeoutFlag <= 1'b0;
    end else begin
      r_timeoutFlag <= w_timeout;
      if (r_state == LOAD) begin
        r_toCount <= '0;
      end else if (r_state == WAIT) begin
        r_toCount <= r_toCount + 26'd1;
      end
      if (r_state == WAIT) begin
        r_miss <= w_timeout;
      end
    end
  end

  assign w_forceMiss  = r_miss;
  assign timeout_flag = r_timeoutFlag;
`else
  assign w_timeout   = 1'b0;
  assign w_forceMiss = 1'b0;
`endif

  // State register plus every datapath register of the round. Reset is
  // honoured in any state, including mid-round, and drops everything back
  // to an idle, all-zero view.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= IDLE;
      r_index    <= '0;
      r_rn       <= '0;
      r_expected <= '0;
      r_answer   <= '0;
      r_score    <= '0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
    end else begin
      r_state    <= w_stateNext;
      r_index    <= w_indexNext;
      r_rn       <= w_rnNext;
      r_expected <= w_expectedNext;
      r_answer   <= w_answerNext;
      r_score    <= w_scoreNext;
      r_done     <= w_doneNext;
      r_pass     <= w_passNext;
    end
  end

  // Next-state and datapath decisions. The read address is loaded together
  // with the index (on round start and on advancing) so that rn is already
  // valid in FETCH; LOAD then captures q after rn has been stable for a full
  // cycle. check_start is only looked at in IDLE and DONE, which is what
  // makes it harmless while a round is running, including in the final
  // COMPARE cycle. Key pulses are only consumed in WAIT; anywhere else they
  // simply fall on the floor rather than being remembered.
  always_comb begin
    w_stateNext    = r_state;
    w_indexNext    = r_index;
    w_rnNext       = r_rn;
    w_expectedNext = r_expected;
    w_answerNext   = r_answer;
    w_scoreNext    = r_score;
    w_doneNext     = r_done;
    w_passNext     = r_pass;

    case (r_state)
      IDLE, DONE: begin
        if (check_start) begin
          w_stateNext = FETCH;
          w_indexNext = '0;
          w_rnNext    = '0;
          w_scoreNext = '0;
          w_doneNext  = 1'b0;
          w_passNext  = 1'b0;
        end
      end

      FETCH: begin
        w_rnNext    = r_index;
        w_stateNext = LOAD;
      end

      LOAD: begin
        w_expectedNext = rf.q;
        w_stateNext    = WAIT;
      end

      WAIT: begin
        if (w_press) begin
          w_answerNext = sw;
          w_stateNext  = COMPARE;
        end else if (w_timeout) begin
          w_stateNext = COMPARE;
        end
      end

      COMPARE: begin
        if (!w_forceMiss && (r_answer == r_expected)) begin
          w_scoreNext = r_score + 4'd1;
        end
        if (r_index == LAST_INDEX) begin
          w_stateNext = DONE;
          w_doneNext  = 1'b1;
          w_passNext  = (w_scoreNext == ROUND_SIZE);
        end else begin
          w_indexNext = r_index + 4'd1;
          w_rnNext    = r_index + 4'd1;
          w_stateNext = FETCH;
        end
      end

      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // The LEDs follow the switches live while an answer is being entered so
  // the player sees what will be submitted, and show all-on / all-off as the
  // round verdict in DONE.
  always_comb begin
    led = '0;
    if (r_state == WAIT) begin
      led = sw;
    end else if (r_state == DONE) begin
      led = r_pass ? 10'h3FF : 10'h000;
    end
  end

  assign busy  = (r_state == FETCH) || (r_state == LOAD) ||
                 (r_state == WAIT)  || (r_state == COMPARE);
  assign done  = r_done;
  assign pass  = r_pass;
  assign score = r_score;
  assign rf.rn = r_rn;

endmodule
